// File: rtl/program_sequencer.sv
// Program sequencer: fetch PC with stall, PS-field next-PC select, circular return-address stack and sticky flags.
// Optional SEQ_ALIGN_CHECK_EN: trap misaligned branch/return destinations instead of masking their low bits.
module program_sequencer #(
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    INSTR_BYTES  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_stall,
  input  logic [1:0]                   i_ps,
  input  logic [ADDR_WIDTH-1:0]        i_target,
  input  logic [ADDR_WIDTH-1:0]        i_offset,
  input  logic                         i_call,
  input  logic                         i_ret,
  input  logic                         i_clear_flags,
  output logic [ADDR_WIDTH-1:0]        o_pc,
  output logic [ADDR_WIDTH-1:0]        o_pc4,
  output logic [$clog2(RAS_DEPTH):0]   o_ras_count,
  output logic                         o_ras_overflow,
  output logic                         o_ras_underflow,
  output logic                         o_align_fault
);

  localparam int OFF_SH = $clog2(INSTR_BYTES);
  localparam int PTR_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]      r_top;
  logic [CNT_W-1:0]      r_count;
  logic                  r_ras_overflow;
  logic                  r_ras_underflow;
  logic                  r_align_fault;

  logic [ADDR_WIDTH-1:0] w_pc4;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [ADDR_WIDTH-1:0] w_dest;
  logic [PTR_W-1:0]      w_top_m1;
  logic                  w_branch;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ovf_set;
  logic                  w_udf_set;
  logic                  w_align_set;

  assign w_pc4    = r_pc + ADDR_WIDTH'(INSTR_BYTES);
  assign w_top_m1 = r_top - PTR_ONE;

  // Next-PC selection: ret outranks the PS field; branches feed the alignment stage.
  always_comb begin
    w_pc_next   = r_pc;
    w_dest      = '0;
    w_branch    = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_udf_set   = 1'b0;
    w_align_set = 1'b0;
    if (!i_stall) begin
      if (i_ret) begin
        if (r_count != '0) begin
          w_pop    = 1'b1;
          w_dest   = r_ras[w_top_m1];
          w_branch = 1'b1;
        end else begin
          w_pc_next = w_pc4;
          w_udf_set = 1'b1;
        end
      end else begin
        case (i_ps)
          2'b00: w_pc_next = r_pc;
          2'b01: w_pc_next = w_pc4;
          2'b10: begin
            w_dest   = i_target;
            w_branch = 1'b1;
            w_push   = i_call;
          end
          2'b11: begin
            w_dest   = r_pc + (i_offset << OFF_SH);
            w_branch = 1'b1;
            w_push   = i_call;
          end
          default: w_pc_next = r_pc;
        endcase
      end
      if (w_branch) begin
`ifdef SEQ_ALIGN_CHECK_EN
        if ((w_dest & ALIGN_MASK) != '0) begin
          // A trapped branch keeps the PC and suppresses the call push; a pop still retires.
          w_pc_next   = r_pc;
          w_push      = 1'b0;
          w_align_set = 1'b1;
        end else begin
          w_pc_next = w_dest;
        end
`else
        w_pc_next = w_dest & ~ALIGN_MASK;
`endif
      end else begin
        w_align_set = 1'b0;
      end
    end else begin
      w_pc_next = r_pc;
    end
  end

  assign w_ovf_set = w_push && (r_count == CNT_FULL);

  // PC, stack pointer, occupancy and sticky flags.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pc            <= RESET_VECTOR;
      r_top           <= '0;
      r_count         <= '0;
      r_ras_overflow  <= 1'b0;
      r_ras_underflow <= 1'b0;
      r_align_fault   <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_push) begin
        r_top <= r_top + PTR_ONE;
        if (r_count != CNT_FULL) begin
          r_count <= r_count + CNT_ONE;
        end
      end else if (w_pop) begin
        r_top   <= w_top_m1;
        r_count <= r_count - CNT_ONE;
      end
      r_ras_overflow  <= w_ovf_set   | (r_ras_overflow  & ~i_clear_flags);
      r_ras_underflow <= w_udf_set   | (r_ras_underflow & ~i_clear_flags);
      r_align_fault   <= w_align_set | (r_align_fault   & ~i_clear_flags);
    end
  end

  // Stack storage; a full stack overwrites its oldest slot because the pointer wraps.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_ras[r_top] <= w_pc4;
    end
  end

  assign o_pc            = r_pc;
  assign o_pc4           = w_pc4;
  assign o_ras_count     = r_count;
  assign o_ras_overflow  = r_ras_overflow;
  assign o_ras_underflow = r_ras_underflow;
`ifdef SEQ_ALIGN_CHECK_EN
  assign o_align_fault   = r_align_fault;
`else
  assign o_align_fault   = 1'b0;
`endif

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Parametrised successor to the processor's program counter stage: holds the fetch address (PC), computes the sequential address (PC plus one instruction), and applies the control word's PS field.
- Adds three things the current counter lacks: a fetch-stall input, call/return support through a return-address stack (RAS) of configurable depth, and sticky error flags.
- Sits between the control unit (PS, call/ret, stall), the datapath (branch target, offset) and the instruction ROM (PC).

Parameters:
- ADDR_WIDTH, 64: width of PC, target and offset.
- INSTR_BYTES, 4: bytes per instruction. Must be a power of two, at least 1.
- RESET_VECTOR, 0: PC value loaded on reset.
- RAS_DEPTH, 4: number of return-address stack entries. Must be a power of two, at least 2.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  1 = freeze all state this cycle
- ps  in  2  PC select: 00 hold, 01 increment, 10 absolute, 11 relative
- target  in  ADDR_WIDTH  absolute branch target (used when ps=10)
- offset  in  ADDR_WIDTH  signed instruction-count offset (used when ps=11)
- call  in  1  push PC4 when the branch is taken
- ret  in  1  pop the RAS into PC
- clear_flags  in  1  synchronous clear of the sticky flags
- pc  out  ADDR_WIDTH  current fetch address
- pc4  out  ADDR_WIDTH  pc + INSTR_BYTES (combinational)
- ras_count  out  clog2(RAS_DEPTH)+1  number of valid RAS entries
- ras_overflow  out  1  sticky: a push was made while the RAS was full
- ras_underflow  out  1  sticky: a pop was made while the RAS was empty
- align_fault  out  1  sticky misaligned-target flag (see Optional Feature)

Behaviour:
- Reset: asynchronous, active-high.
  - pc = RESET_VECTOR, ras_count = 0, all flags = 0.
  - RAS contents are don't-care.
  - Reset asserted mid-operation aborts any update; the first update after release happens on the first clock edge with reset low.
- pc4 = pc + INSTR_BYTES, modulo 2^ADDR_WIDTH (wraps silently).
- All state changes occur on the rising clock edge. pc reflects the new value one cycle after the controlling inputs are sampled.
- stall=1: pc, RAS and ras_count hold. ps, call and ret are ignored. clear_flags is still honoured.
- When stall=0, next-PC is chosen by priority, highest first:
  1. ret=1:
     - RAS not empty: pc <- top entry, ras_count decrements.
     - RAS empty: pc <- pc4, ras_underflow <- 1, ras_count stays 0.
     - call and ps are ignored this cycle.
  2. ps=00: pc holds.
  3. ps=01: pc <- pc4.
  4. ps=10: pc <- target.
  5. ps=11: pc <- pc + (offset << log2(INSTR_BYTES)).
     - offset is two's complement; the sum is modulo 2^ADDR_WIDTH.
- call=1 (with ret=0):
  - Acts only when ps=10 or ps=11; with ps=00 or ps=01 it is ignored.
  - Pushes the current pc4 onto the RAS in the same edge as the branch.
  - RAS not full: ras_count increments.
  - RAS full: the RAS is circular, so the oldest entry is overwritten, ras_count stays at RAS_DEPTH and ras_overflow <- 1.
- Pop after an overflow returns the most recent addresses. After RAS_DEPTH pops the RAS is empty.
- Sticky flags:
  - Cleared by clear_flags=1 at the next edge.
  - If a set event occurs in the same cycle as clear_flags, set wins.
- Storage: the RAS is a register array with a top pointer that wraps modulo RAS_DEPTH. No memory macro is inferred.

Optional Feature:
- Macro: SEQ_ALIGN_CHECK_EN.
- Defined:
  - A branch whose resulting address has nonzero bits [log2(INSTR_BYTES)-1:0] is a misaligned branch. This covers ps=10, ps=11, and a ret pop value.
  - On a misaligned branch: pc holds, no RAS push occurs, and align_fault <- 1.
  - A pop still decrements ras_count.
- Not defined:
  - The low log2(INSTR_BYTES) bits of every branch/return destination are forced to 0.
  - align_fault is tied to 0.

Test Plan:
- Reset: RESET_VECTOR=0x100, hold reset 3 cycles, then ps=01 for 4 cycles -> pc = 0x100, 0x104, 0x108, 0x10C, 0x110; ras_count=0; all flags 0.
- Stall: at pc=0x20, stall=1 with ps=10, target=0x400, call=1 for 2 cycles -> pc stays 0x20 and ras_count stays 0. Then stall=0 -> pc=0x400, ras_count=1.
- Call/return nesting: from pc=0x0, call to 0x40, then call to 0x80, then ret, ret -> pc = 0x40, 0x80, 0x44, 0x4; ras_count = 1, 2, 1, 0.
- Overflow and underflow (RAS_DEPTH=4): 5 calls to 0x1000 from pc 0x0, then 0x1000 each time -> ras_overflow=1, ras_count=4. Then 5 rets: the first 4 pops are the last four pushed pc4 values; the 5th sets ras_underflow=1 and pc advances to pc4. clear_flags=1 -> both flags 0.
- Relative wrap: pc=0x8, ps=11, offset=-3 -> pc = 0xFFFF_FFFF_FFFF_FFFC (64-bit). Then ps=01 -> pc=0x0.
- Alignment:
  - With SEQ_ALIGN_CHECK_EN, ps=10, target=0x202 -> pc holds and align_fault=1.
  - Without the macro, the same stimulus -> pc=0x200 and align_fault=0.
